pipe_hazard_ctrl: RTL and testbench

Sequencing controller for the five-stage RISC-V pipeline. It generates every per-stage stall and flush from three sources: load-use hazards detected between ID and EX, multi-cycle data-memory accesses (req/ready handshake), and branch/jump redirects from EX. It replaces the purely combinational flush logic. It adds a memory-wait state machine with timeout and a pending-flush register, so a redirect that arrives during a memory stall is never lost.

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline stall/flush sequencer: load-use, multi-cycle dmem wait with timeout, EX redirects.
// Optional perf counters when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs1_id,
  input  logic [4:0] rs2_id,
  input  logic       rs1_used_id,
  input  logic       rs2_used_id,
  input  logic [4:0] rd_ex,
  input  logic       mem_read_ex,
  input  logic       branch_taken,
  input  logic       branch_mispredicted,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       stall_fetch_dec,
  output logic       stall_dec_ex,
  output logic       stall_ex_mem,
  output logic       flush_fetch_dec,
  output logic       flush_dec_ex,
  output logic       flush_ex_mem,
  output logic       mem_timeout
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_count
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, cnt_nxt;
  logic [1:0]       pend, pend_nxt;   // [1] = de, [0] = fd
  logic             lu_hazard, mem_stall, timeout;
  logic             redir_fd, redir_de;

  assign lu_hazard = mem_read_ex & (rd_ex != 5'd0) &
                     (((rd_ex == rs1_id) & rs1_used_id) | ((rd_ex == rs2_id) & rs2_used_id));
  assign mem_stall = dmem_req & ~dmem_ready;

  // wait_cnt is 0 in RUN, so MEM_TIMEOUT=1 times out on the very first wait cycle.
  assign timeout = ~dmem_ready & ((state == MEM_WAIT) | dmem_req) &
                   (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  assign redir_de = branch_mispredicted | pend[1];
  assign redir_fd = redir_de | branch_taken | pend[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      pend     <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= cnt_nxt;
      pend     <= pend_nxt;
    end
  end

  always_comb begin
    state_nxt = RUN;
    cnt_nxt   = '0;
    pend_nxt  = '0;
    if (!timeout && mem_stall) begin
      state_nxt = MEM_WAIT;
      cnt_nxt   = wait_cnt + 1'b1;
      pend_nxt  = pend | {branch_mispredicted, branch_mispredicted | branch_taken};
    end
  end

  // Outputs are forced low while reset is asserted, independent of the inputs.
  always_comb begin
    stall_fetch_dec = 1'b0;
    stall_dec_ex    = 1'b0;
    stall_ex_mem    = 1'b0;
    flush_fetch_dec = 1'b0;
    flush_dec_ex    = 1'b0;
    flush_ex_mem    = 1'b0;
    mem_timeout     = 1'b0;
    if (!reset) begin
      if (timeout) begin
        mem_timeout     = 1'b1;
        flush_ex_mem    = 1'b1;
        flush_fetch_dec = redir_fd;
        flush_dec_ex    = redir_de;
      end else if (mem_stall) begin
        stall_fetch_dec = 1'b1;
        stall_dec_ex    = 1'b1;
        stall_ex_mem    = 1'b1;
      end else begin
        flush_fetch_dec = redir_fd;
        flush_dec_ex    = redir_de;
        // A redirect squashes the dependent instruction, so the bubble is moot.
        if (!redir_fd && lu_hazard) begin
          stall_fetch_dec = 1'b1;
          flush_dec_ex    = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall_fetch_dec) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_fetch_dec) perf_flush_count  <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each driven cycle queues its expected outputs,
// a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] rs1_id = '0, rs2_id = '0, rd_ex = '0;
  logic rs1_used_id = 1'b0, rs2_used_id = 1'b0, mem_read_ex = 1'b0;
  logic branch_taken = 1'b0, branch_mispredicted = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic stall_fetch_dec, stall_dec_ex, stall_ex_mem;
  logic flush_fetch_dec, flush_dec_ex, flush_ex_mem, mem_timeout;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flush_count;
`endif

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
    .rd_ex(rd_ex), .mem_read_ex(mem_read_ex),
    .branch_taken(branch_taken), .branch_mispredicted(branch_mispredicted),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_fetch_dec(stall_fetch_dec), .stall_dec_ex(stall_dec_ex), .stall_ex_mem(stall_ex_mem),
    .flush_fetch_dec(flush_fetch_dec), .flush_dec_ex(flush_dec_ex), .flush_ex_mem(flush_ex_mem),
    .mem_timeout(mem_timeout)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Expected output vector: {sfd, sde, sem, ffd, fde, fem, to}
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1000100;
  localparam logic [6:0] MP   = 7'b0001100;
  localparam logic [6:0] TK   = 7'b0001000;
  localparam logic [6:0] MS   = 7'b1110000;
  localparam logic [6:0] TO   = 7'b0000011;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, mr, bt, bm, req, rdy;
  } in_t;

  in_t        nx;
  string      tag_q[$];
  logic [6:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [6:0] e);
    @(posedge clk);
    #1;
    reset               = nx.rst;
    rs1_id              = nx.rs1;
    rs2_id              = nx.rs2;
    rd_ex               = nx.rd;
    rs1_used_id         = nx.u1;
    rs2_used_id         = nx.u2;
    mem_read_ex         = nx.mr;
    branch_taken        = nx.bt;
    branch_mispredicted = nx.bm;
    dmem_req            = nx.req;
    dmem_ready          = nx.rdy;
    tag_q.push_back(tag);
    exp_q.push_back(e);
    nx = '0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      string      t;
      logic [6:0] e;
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      chk(t, {25'd0, stall_fetch_dec, stall_dec_ex, stall_ex_mem,
              flush_fetch_dec, flush_dec_ex, flush_ex_mem, mem_timeout}, {25'd0, e});
    end
  end

  initial begin
    nx = '0;
    nx.rst = 1'b1;                                  cyc("reset", NONE);

    // memory wait 3 cycles, mispredict on wait cycle 2, release on 4th
    nx.req = 1; nx.rdy = 0;                         cyc("mw1", MS);
    nx.req = 1; nx.rdy = 0; nx.bm = 1;              cyc("mw2_mp", MS);
    nx.req = 1; nx.rdy = 0;                         cyc("mw3", MS);
    nx.req = 1; nx.rdy = 1;                         cyc("mw_release", MP);
                                                    cyc("mw_after", NONE);
`ifdef PIPE_HAZARD_PERF_EN
    chk("perf_stall", perf_stall_cycles, 32'd3);
    chk("perf_flush", perf_flush_count, 32'd1);
`endif

    // load-use
    nx.mr = 1; nx.rd = 5; nx.rs1 = 5; nx.u1 = 1;    cyc("lu_rs1", LU);
                                                    cyc("lu_over", NONE);
    nx.mr = 1; nx.rd = 0; nx.rs1 = 0; nx.u1 = 1;    cyc("lu_x0", NONE);
    nx.mr = 1; nx.rd = 9; nx.rs2 = 9; nx.u2 = 1;    cyc("lu_rs2", LU);
    nx.mr = 1; nx.rd = 9; nx.rs1 = 9; nx.u1 = 0;    cyc("lu_unused", NONE);
    nx.mr = 0; nx.rd = 7; nx.rs1 = 7; nx.u1 = 1;    cyc("lu_noload", NONE);

    // redirects
    nx.bm = 1;                                      cyc("mispredict", MP);
    nx.bt = 1;                                      cyc("taken", TK);
                                                    cyc("redir_idle", NONE);
    nx.mr = 1; nx.rd = 3; nx.rs1 = 3; nx.u1 = 1; nx.bm = 1; cyc("lu_mp", MP);
    nx.mr = 1; nx.rd = 3; nx.rs2 = 3; nx.u2 = 1; nx.bt = 1; cyc("lu_tk", TK);

    // timeout (MEM_TIMEOUT=4)
    for (int i = 0; i < 3; i++) begin
      nx.req = 1;                                   cyc("to_wait", MS);
    end
    nx.req = 1;                                     cyc("timeout", TO);
                                                    cyc("to_after", NONE);

    // timeout with a taken redirect pending
    nx.req = 1;                                     cyc("top_w1", MS);
    nx.req = 1; nx.bt = 1;                          cyc("top_w2_tk", MS);
    nx.req = 1;                                     cyc("top_w3", MS);
    nx.req = 1;                                     cyc("top_timeout", TO | TK);
                                                    cyc("top_after", NONE);

    // reset mid-wait drops outputs and discards the pending flush
    nx.req = 1; nx.bm = 1;                          cyc("rw_w1_mp", MS);
    nx.rst = 1; nx.req = 1;                         cyc("rw_reset", NONE);
                                                    cyc("rw_release", NONE);
                                                    cyc("rw_after", NONE);

    // single-cycle access and stray ready
    nx.req = 1; nx.rdy = 1;                         cyc("req_ready", NONE);
    nx.rdy = 1;                                     cyc("ready_noreq", NONE);
                                                    cyc("final", NONE);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
